mmu_sequencer: RTL and testbench
================================

MMU_SEQUENCER -- requirements
Module: mmu_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 4, systolic array dimension.
REQ-002 SHALL have parameter ELEM_W, default 8, element width; word width ROWS*ELEM_W = 32, result width ROWS*4*ELEM_W = 128.
REQ-003 SHALL have parameter MAX_ACT, default 32, maximum activation rows per job.
REQ-004 SHALL have parameter RES_LAT, default 2*ROWS, cycles from activation word presented to MMU until its acc_out row is valid.
REQ-005 SHALL have ports `clk  in  1  clock`; all logic is on the rising edge.
REQ-006 SHALL have port `reset_n  in  1  asynchronous active-low reset`.
REQ-007 SHALL have ports `start  in  1  job request` and `abort  in  1  cancel job`.
REQ-008 SHALL have port `cfg_num_act  in  $clog2(MAX_ACT+1)  activation row count`, sampled at start.
REQ-009 SHALL have ports `busy  out  1` and `done  out  1  one-cycle pulse`.
REQ-010 SHALL have ports `wt_rd_en  out  1`, `wt_rd_addr  out  $clog2(ROWS)`, and `wt_rd_data  in  32`; read latency is 1 cycle.
REQ-011 SHALL have ports `act_rd_en  out  1`, `act_rd_addr  out  $clog2(MAX_ACT)`, and `act_rd_data  in  32`; read latency is 1 cycle.
REQ-012 SHALL have ports `mmu_control  out  1`, `mmu_wt_arr  out  32`, `mmu_data_arr  out  32`, and `mmu_acc_out  in  128`.
REQ-013 SHALL have ports `res_valid  out  1`, `res_idx  out  $clog2(MAX_ACT)`, and `res_data  out  128`; there is no backpressure.
REQ-014 SHALL have port `perf_cycles  out  32`.

Function
REQ-015 SHALL implement the FSM IDLE -> LOAD_WT -> FEED_ACT -> DRAIN -> DONE -> IDLE.
REQ-016 IDLE: when start=1 and 1<=cfg_num_act<=MAX_ACT, SHALL latch the count and go to LOAD_WT next cycle; start with cfg_num_act=0 or >MAX_ACT SHALL be ignored.
REQ-017 start while busy=1 SHALL be ignored.
REQ-018 LOAD_WT SHALL issue wt_rd_en with addresses 0..ROWS-1 on consecutive cycles, ROWS cycles total.
REQ-019 Each read word SHALL drive mmu_wt_arr the cycle after issue, with mmu_control=1 in exactly those ROWS cycles.
REQ-020 FEED_ACT SHALL start the cycle after the last weight issue and issue act_rd_en with addresses 0..N-1, N=latched count, one per cycle.
REQ-021 The activation word SHALL drive mmu_data_arr the cycle after issue, with mmu_control=0.
REQ-022 Outside presentation cycles, mmu_data_arr and mmu_wt_arr SHALL be 0; mmu_control=0 except during weight presentation.
REQ-023 The activation row k presented at cycle P SHALL produce res_valid=1, res_idx=k, res_data=mmu_acc_out sampled at cycle P+RES_LAT, for one cycle per row, in order.
REQ-024 DRAIN SHALL hold until the result for row N-1 is emitted; then DONE SHALL assert done for one cycle and return to IDLE.
REQ-025 Job length start->done SHALL be 1+ROWS+N+RES_LAT+1 cycles (N=4: 18 cycles).
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 abort in any busy state SHALL go to IDLE next cycle, deassert rd_en/mmu_control, flush in-flight result tags (no further res_valid), and not pulse done.
REQ-028 abort and start in the same cycle in IDLE: start wins, abort is ignored.
REQ-029 Address counters SHALL not wrap within a job; act_rd_addr never exceeds N-1.

Reset
REQ-030 While reset_n=0: state=IDLE; busy, done, wt_rd_en, act_rd_en, mmu_control, res_valid = 0; all addresses, mmu_wt_arr, mmu_data_arr, res_idx, res_data, perf_cycles = 0; in-flight tags cleared.
REQ-031 Reset asserted mid-job SHALL drop the job with no done and no residual res_valid after release.

Configuration
REQ-032 With MMU_SEQ_PERF_EN defined, perf_cycles SHALL count busy cycles of the current/last job, clear on accepted start, saturate at 2^32-1, and hold after done.
REQ-033 Without MMU_SEQ_PERF_EN, perf_cycles SHALL be constant 0 with no counter logic.

Structure
REQ-034 Package mmu_pkg SHALL hold ROWS, ELEM_W, word/result width constants, and the FSM state enum typedef.
REQ-035 Sub-module mmu_seq_tag_pipe SHALL be a RES_LAT-deep shift register of {valid, idx} with synchronous flush, used to time res_valid/res_idx.

Verification
REQ-036 Bench SHALL cover: start, cfg_num_act=4, wt mem = 0x01010101 all rows, act row k = 0x0k0k0k0k -> mmu_control high 4 cycles, res_idx 0..3 in order, done exactly 18 cycles after start.
REQ-037 Bench SHALL cover: cfg_num_act=0 with start -> busy stays 0, no rd_en, no done.
REQ-038 Bench SHALL cover: start again 3 cycles into a job with cfg_num_act=2 -> ignored; original 4-row job completes unchanged.
REQ-039 Bench SHALL cover: abort during FEED_ACT after 2 issues -> IDLE next cycle, zero res_valid thereafter, no done; a following start with count 1 completes normally.
REQ-040 Bench SHALL cover: reset_n low for 1 cycle during DRAIN -> all outputs 0 immediately, no res_valid after release.
REQ-041 Bench SHALL cover: with MMU_SEQ_PERF_EN, a 4-row job -> perf_cycles=17 after done; without the macro -> perf_cycles=0.

Source files
------------

// File: rtl/mmu_pkg.sv
// ============================================================================
// Module      : mmu_pkg
// Description : Shared constants and FSM state type for the MMU job sequencer.
//               Optional build macro used by the sequencer: MMU_SEQ_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmu_pkg;

  // Default systolic array geometry
  localparam int DEF_ROWS   = 4;
  localparam int DEF_ELEM_W = 8;

  // One array row of elements, and one accumulator result row
  localparam int WORD_W = DEF_ROWS * DEF_ELEM_W;
  localparam int RES_W  = DEF_ROWS * 4 * DEF_ELEM_W;

  // Sequencer job phases
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_WT  = 3'd1,
    ST_FEED_ACT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } mmu_state_e;

endpackage : mmu_pkg

`default_nettype wire

// File: rtl/mmu_seq_tag_pipe.sv
// ============================================================================
// Module      : mmu_seq_tag_pipe
// Description : Fixed-depth shift register of {valid, row index} tags that
//               tracks activation rows travelling through the MMU so their
//               results can be flagged when they appear. Synchronous flush
//               discards every in-flight tag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmu_seq_tag_pipe #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [DEPTH-1:0]            r_vld;
  logic [DEPTH-1:0][IDX_W-1:0] r_idx;

  // Shift tags one stage per cycle; flush wipes every stage at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      r_idx <= '0;
    end else if (i_flush) begin
      r_vld <= '0;
      r_idx <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_idx[0] <= i_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_idx   = r_idx[DEPTH-1];

endmodule : mmu_seq_tag_pipe

`default_nettype wire

// File: rtl/mmu_sequencer.sv
// ============================================================================
// Module      : mmu_sequencer
// Description : Job sequencer for a systolic matrix-multiply unit. Loads ROWS
//               weight words, streams N activation rows, then collects the N
//               result rows RES_LAT cycles after each presentation.
//               Build macro MMU_SEQ_PERF_EN enables the job cycle counter on
//               perf_cycles; otherwise perf_cycles is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmu_sequencer #(
  parameter int ROWS    = mmu_pkg::DEF_ROWS,
  parameter int ELEM_W  = mmu_pkg::DEF_ELEM_W,
  parameter int MAX_ACT = 32,
  parameter int RES_LAT = 2 * ROWS
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [$clog2(MAX_ACT+1)-1:0]   cfg_num_act,
  output logic                           busy,
  output logic                           done,
  output logic                           wt_rd_en,
  output logic [$clog2(ROWS)-1:0]        wt_rd_addr,
  input  logic [ROWS*ELEM_W-1:0]         wt_rd_data,
  output logic                           act_rd_en,
  output logic [$clog2(MAX_ACT)-1:0]     act_rd_addr,
  input  logic [ROWS*ELEM_W-1:0]         act_rd_data,
  output logic                           mmu_control,
  output logic [ROWS*ELEM_W-1:0]         mmu_wt_arr,
  output logic [ROWS*ELEM_W-1:0]         mmu_data_arr,
  input  logic [ROWS*4*ELEM_W-1:0]       mmu_acc_out,
  output logic                           res_valid,
  output logic [$clog2(MAX_ACT)-1:0]     res_idx,
  output logic [ROWS*4*ELEM_W-1:0]       res_data,
  output logic [31:0]                    perf_cycles
);

  import mmu_pkg::*;

  localparam int CNT_W = $clog2(MAX_ACT + 1);
  localparam int WA_W  = $clog2(ROWS);
  localparam int IDX_W = $clog2(MAX_ACT);

  mmu_state_e       r_state;
  logic [CNT_W-1:0] r_num;
  logic             r_busy;
  logic             r_done;
  logic             r_wt_rd_en;
  logic [WA_W-1:0]  r_wt_addr;
  logic             r_act_rd_en;
  logic [IDX_W-1:0] r_act_addr;
  logic             r_wt_pres;
  logic             r_act_pres;
  logic [IDX_W-1:0] r_act_idx;

  logic             w_start_ok;
  logic             w_abort;
  logic             w_last_wt;
  logic             w_last_act;
  logic             w_last_res;
  logic             w_tag_valid;
  logic [IDX_W-1:0] w_tag_idx;

  // Only idle, in-range requests start a job; abort only matters mid-job
  assign w_start_ok = start && (cfg_num_act != '0) && (cfg_num_act <= CNT_W'(MAX_ACT));
  assign w_abort    = abort && (r_state != ST_IDLE);
  assign w_last_wt  = (r_wt_addr == WA_W'(ROWS - 1));
  assign w_last_act = (CNT_W'(r_act_addr) == (r_num - CNT_W'(1)));
  assign w_last_res = w_tag_valid && (CNT_W'(w_tag_idx) == (r_num - CNT_W'(1)));

  // Job FSM with registered read strobes, addresses and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_num       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wt_rd_en  <= 1'b0;
      r_wt_addr   <= '0;
      r_act_rd_en <= 1'b0;
      r_act_addr  <= '0;
      r_wt_pres   <= 1'b0;
      r_act_pres  <= 1'b0;
      r_act_idx   <= '0;
    end else begin
      r_done     <= 1'b0;
      // Read data returns one cycle after issue; that is the presentation cycle
      r_wt_pres  <= r_wt_rd_en && !w_abort;
      r_act_pres <= r_act_rd_en && !w_abort;
      r_act_idx  <= r_act_addr;
      if (w_abort) begin
        r_state     <= ST_IDLE;
        r_busy      <= 1'b0;
        r_wt_rd_en  <= 1'b0;
        r_act_rd_en <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start_ok) begin
              r_state    <= ST_LOAD_WT;
              r_busy     <= 1'b1;
              r_num      <= cfg_num_act;
              r_wt_rd_en <= 1'b1;
              r_wt_addr  <= '0;
              r_act_addr <= '0;
            end
          end
          ST_LOAD_WT: begin
            if (w_last_wt) begin
              r_state     <= ST_FEED_ACT;
              r_wt_rd_en  <= 1'b0;
              r_act_rd_en <= 1'b1;
              r_act_addr  <= '0;
            end else begin
              r_wt_addr <= r_wt_addr + WA_W'(1);
            end
          end
          ST_FEED_ACT: begin
            if (w_last_act) begin
              r_state     <= ST_DRAIN;
              r_act_rd_en <= 1'b0;
            end else begin
              r_act_addr <= r_act_addr + IDX_W'(1);
            end
          end
          ST_DRAIN: begin
            if (w_last_res) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Tags enter when an activation row is presented and emerge RES_LAT later
  mmu_seq_tag_pipe #(
    .DEPTH (RES_LAT),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (w_abort),
    .i_valid (r_act_pres),
    .i_idx   (r_act_idx),
    .o_valid (w_tag_valid),
    .o_idx   (w_tag_idx)
  );

`ifdef MMU_SEQ_PERF_EN
  logic [31:0] r_perf;

  // Count working cycles from first weight issue through the last result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf <= '0;
    end else if ((r_state == ST_IDLE) && w_start_ok) begin
      r_perf <= '0;
    end else if (((r_state == ST_LOAD_WT) || (r_state == ST_FEED_ACT) ||
                  (r_state == ST_DRAIN)) && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = '0;
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign wt_rd_en     = r_wt_rd_en;
  assign wt_rd_addr   = r_wt_addr;
  assign act_rd_en    = r_act_rd_en;
  assign act_rd_addr  = r_act_addr;
  assign mmu_control  = r_wt_pres;
  assign mmu_wt_arr   = r_wt_pres ? wt_rd_data : '0;
  assign mmu_data_arr = r_act_pres ? act_rd_data : '0;
  assign res_valid    = w_tag_valid;
  assign res_idx      = w_tag_idx;
  assign res_data     = w_tag_valid ? mmu_acc_out : '0;

endmodule : mmu_sequencer

`default_nettype wire

// File: tb/tb_mmu_sequencer.sv
// ============================================================================
// Module      : tb_mmu_sequencer
// Description : Self-checking bench for mmu_sequencer with a cycle-indexed
//               vector table for the nominal 4-row job plus directed
//               sequences for rejection, abort and mid-job reset.
//               Honours MMU_SEQ_PERF_EN for the perf_cycles expectation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmu_sequencer;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         wt_en;
    logic [1:0]   wt_a;
    logic         act_en;
    logic [4:0]   act_a;
    logic         ctl;
    logic [31:0]  wt_arr;
    logic [31:0]  data_arr;
    logic         rv;
    logic [4:0]   ridx;
    logic [127:0] rdata;
  } obs_t;

  typedef struct {
    logic       start;
    logic [5:0] cfg;
    obs_t       exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [5:0]   cfg_num_act = '0;
  logic         busy, done, wt_rd_en, act_rd_en, mmu_control, res_valid;
  logic [1:0]   wt_rd_addr;
  logic [4:0]   act_rd_addr, res_idx;
  logic [31:0]  wt_rd_data = '0;
  logic [31:0]  act_rd_data = '0;
  logic [31:0]  mmu_wt_arr, mmu_data_arr, perf_cycles;
  logic [127:0] mmu_acc_out, res_data;

  logic [31:0]  wt_mem [0:3];
  logic [31:0]  act_mem [0:31];
  logic [31:0]  d_neg = '0;
  logic [31:0]  hist [0:7];

  vec_t         tbl [0:19];
  int           n_total = 0;
  int           n_pass = 0;

  localparam logic [31:0] PERF_EXP =
`ifdef MMU_SEQ_PERF_EN
    32'd17;
`else
    32'd0;
`endif

  mmu_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .cfg_num_act  (cfg_num_act),
    .busy         (busy),
    .done         (done),
    .wt_rd_en     (wt_rd_en),
    .wt_rd_addr   (wt_rd_addr),
    .wt_rd_data   (wt_rd_data),
    .act_rd_en    (act_rd_en),
    .act_rd_addr  (act_rd_addr),
    .act_rd_data  (act_rd_data),
    .mmu_control  (mmu_control),
    .mmu_wt_arr   (mmu_wt_arr),
    .mmu_data_arr (mmu_data_arr),
    .mmu_acc_out  (mmu_acc_out),
    .res_valid    (res_valid),
    .res_idx      (res_idx),
    .res_data     (res_data),
    .perf_cycles  (perf_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rowword(int k);
    logic [7:0] b;
    b = 8'(k);
    return {b, b, b, b};
  endfunction

  // Stand-in MMU result: a distinctive mix of the presented activation word
  function automatic logic [127:0] accf(logic [31:0] w);
    return {w ^ 32'hA5A5_A5A5, w, ~w, w + 32'h1357_9BDF};
  endfunction

  // Memories with one-cycle read latency
  always @(posedge clk) begin
    if (wt_rd_en)  wt_rd_data  <= wt_mem[wt_rd_addr];
    if (act_rd_en) act_rd_data <= act_mem[act_rd_addr];
  end

  // MMU latency model: the word presented in cycle P comes back in cycle P+8
  always @(negedge clk) d_neg <= mmu_data_arr;
  always @(posedge clk) begin
    hist[0] <= d_neg;
    for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
  end
  assign mmu_acc_out = accf(hist[7]);

  function automatic obs_t sample();
    obs_t o;
    o.busy     = busy;
    o.done     = done;
    o.wt_en    = wt_rd_en;
    o.wt_a     = wt_rd_en ? wt_rd_addr : 2'd0;
    o.act_en   = act_rd_en;
    o.act_a    = act_rd_en ? act_rd_addr : 5'd0;
    o.ctl      = mmu_control;
    o.wt_arr   = mmu_wt_arr;
    o.data_arr = mmu_data_arr;
    o.rv       = res_valid;
    o.ridx     = res_valid ? res_idx : 5'd0;
    o.rdata    = res_valid ? res_data : 128'd0;
    return o;
  endfunction

  function automatic logic [319:0] raw_all();
    return 320'({busy, done, wt_rd_en, wt_rd_addr, act_rd_en, act_rd_addr,
                 mmu_control, mmu_wt_arr, mmu_data_arr, res_valid, res_idx,
                 res_data, perf_cycles});
  endfunction

  task automatic chk(string name, logic [319:0] act, logic [319:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(int i, bit s, bit b, bit d, bit we, int wa, bit ae,
                     int aa, bit ctl, int drow, bit rv, int ri);
    tbl[i].start        = s;
    tbl[i].cfg          = 6'd4;
    tbl[i].exp.busy     = b;
    tbl[i].exp.done     = d;
    tbl[i].exp.wt_en    = we;
    tbl[i].exp.wt_a     = 2'(wa);
    tbl[i].exp.act_en   = ae;
    tbl[i].exp.act_a    = 5'(aa);
    tbl[i].exp.ctl      = ctl;
    tbl[i].exp.wt_arr   = ctl ? 32'h0101_0101 : 32'd0;
    tbl[i].exp.data_arr = (drow >= 0) ? rowword(drow) : 32'd0;
    tbl[i].exp.rv       = rv;
    tbl[i].exp.ridx     = rv ? 5'(ri) : 5'd0;
    tbl[i].exp.rdata    = rv ? accf(rowword(ri)) : 128'd0;
  endtask

  initial begin
    int  done_at, n_res, bad;
    bit  seen_done;

    for (int k = 0; k < 4; k++)  wt_mem[k]  = 32'h0101_0101;
    for (int k = 0; k < 32; k++) act_mem[k] = rowword(k);
    for (int k = 0; k < 8; k++)  hist[k]    = '0;

    // Cycle-by-cycle expectation for a 4-row job; row index = cycles since start
    //   i   s  busy done we wa ae aa ctl drow rv ridx
    add(0,  1, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    add(1,  0, 1, 0, 1, 0, 0, 0, 0, -1, 0, 0);
    add(2,  0, 1, 0, 1, 1, 0, 0, 1, -1, 0, 0);
    add(3,  0, 1, 0, 1, 2, 0, 0, 1, -1, 0, 0);
    add(4,  0, 1, 0, 1, 3, 0, 0, 1, -1, 0, 0);
    add(5,  0, 1, 0, 0, 0, 1, 0, 1, -1, 0, 0);
    add(6,  0, 1, 0, 0, 0, 1, 1, 0,  0, 0, 0);
    add(7,  0, 1, 0, 0, 0, 1, 2, 0,  1, 0, 0);
    add(8,  0, 1, 0, 0, 0, 1, 3, 0,  2, 0, 0);
    add(9,  0, 1, 0, 0, 0, 0, 0, 0,  3, 0, 0);
    add(10, 0, 1, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    add(11, 0, 1, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    add(12, 0, 1, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    add(13, 0, 1, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    add(14, 0, 1, 0, 0, 0, 0, 0, 0, -1, 1, 0);
    add(15, 0, 1, 0, 0, 0, 0, 0, 0, -1, 1, 1);
    add(16, 0, 1, 0, 0, 0, 0, 0, 0, -1, 1, 2);
    add(17, 0, 1, 0, 0, 0, 0, 0, 0, -1, 1, 3);
    add(18, 0, 1, 1, 0, 0, 0, 0, 0, -1, 0, 0);
    add(19, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", raw_all(), 320'd0);
    step();
    reset_n = 1'b1;
    step();

    // Nominal job, then the same job with a second start 3 cycles in (cfg=2)
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 20; i++) begin
        if (i > 0) step();
        start       = tbl[i].start || (pass == 1 && i == 3);
        cfg_num_act = (pass == 1 && i == 3) ? 6'd2 : tbl[i].cfg;
        @(negedge clk);
        chk($sformatf("job%0d_cyc%0d", pass, i), 320'(sample()), 320'(tbl[i].exp));
      end
      chk($sformatf("perf_after_done%0d", pass), 320'(perf_cycles), 320'(PERF_EXP));
      step();
      start = 1'b0;
    end

    // Out-of-range counts are rejected
    for (int t = 0; t < 2; t++) begin
      start       = 1'b1;
      cfg_num_act = (t == 0) ? 6'd0 : 6'd33;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
        step();
        start = 1'b0;
        @(negedge clk);
        if (busy || done || wt_rd_en || act_rd_en) bad++;
      end
      chk($sformatf("reject_cfg_%0d", cfg_num_act), 320'(bad), 320'd0);
      step();
    end

    // Abort after two activation issues
    start = 1'b1;
    cfg_num_act = 6'd4;
    for (int c = 1; c <= 7; c++) begin
      step();
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    chk("abort_cycle_act_issue", 320'({act_rd_en, act_rd_addr}), 320'({1'b1, 5'd2}));
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_next_idle", 320'({busy, done, wt_rd_en, act_rd_en, mmu_control, mmu_data_arr}), 320'd0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      @(negedge clk);
      if (res_valid || done || busy) bad++;
    end
    chk("abort_no_residue", 320'(bad), 320'd0);

    // One-row job, started together with an abort in IDLE (start wins)
    step();
    start       = 1'b1;
    abort       = 1'b1;
    cfg_num_act = 6'd1;
    @(negedge clk);
    seen_done = 1'b0;
    done_at   = -1;
    n_res     = 0;
    for (int c = 1; c <= 40 && !seen_done; c++) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      if (res_valid) begin
        n_res++;
        chk("single_res", 320'({res_idx, res_data}), 320'({5'd0, accf(rowword(0))}));
      end
      if (done) begin
        seen_done = 1'b1;
        done_at   = c;
      end
    end
    chk("single_done_latency", 320'(done_at), 320'd15);
    chk("single_res_count", 320'(n_res), 320'd1);

    // Reset pulse while results are draining
    step();
    start = 1'b1;
    cfg_num_act = 6'd4;
    for (int c = 1; c <= 15; c++) begin
      step();
      start = 1'b0;
    end
    chk("drain_before_reset", 320'({res_valid, res_idx}), 320'({1'b1, 5'd1}));
    reset_n = 1'b0;
    #1;
    chk("reset_mid_drain", raw_all(), 320'd0);
    step();
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      @(negedge clk);
      if (res_valid || done || busy || wt_rd_en || act_rd_en) bad++;
    end
    chk("reset_no_residue", 320'(bad), 320'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mmu_sequencer

`default_nettype wire
